// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory responder: independent AW/W capture in either order,
// byte-strobed writes and single-cycle registered reads from a word-addressed register file.
module axi_lite_mem_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [1:0]              s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready
);
    localparam int DEPTH  = 2 ** (ADDR_WIDTH - 2);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_VALID} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [ADDR_WIDTH-1:0]            addr_q;
    logic [DATA_WIDTH-1:0]            data_q;
    logic [NBYTES-1:0]                strb_q;

    logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                  wr_fire, wr_err;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTES-1:0]     wr_strb;

    assign aw_hs = s0_axi_awvalid && s0_axi_awready;
    assign w_hs  = s0_axi_wvalid  && s0_axi_wready;
    assign ar_hs = s0_axi_arvalid && s0_axi_arready;
    assign b_hs  = s0_axi_bvalid  && s0_axi_bready;
    assign r_hs  = s0_axi_rvalid  && s0_axi_rready;

    // Pick the write operands from the live bus or the latched half, depending on which arrived first.
    always_comb begin
        wr_fire = 1'b0;
        wr_addr = s0_axi_awaddr;
        wr_data = s0_axi_wdata;
        wr_strb = s0_axi_wstrb;
        case (w_state)
            W_IDLE:      wr_fire = aw_hs && w_hs;
            W_HAVE_ADDR: begin
                wr_fire = w_hs;
                wr_addr = addr_q;
            end
            W_HAVE_DATA: begin
                wr_fire = aw_hs;
                wr_data = data_q;
                wr_strb = strb_q;
            end
            default:     wr_fire = 1'b0;
        endcase
    end

    assign wr_err = |wr_addr[1:0];

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            w_state        <= W_IDLE;
            s0_axi_awready <= 1'b0;
            s0_axi_wready  <= 1'b0;
            s0_axi_bvalid  <= 1'b0;
            s0_axi_bresp   <= RESP_OKAY;
            addr_q         <= '0;
            data_q         <= '0;
            strb_q         <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s0_axi_awready <= 1'b1;
                    s0_axi_wready  <= 1'b1;
                    if (wr_fire) begin
                        w_state        <= W_RESP;
                        s0_axi_awready <= 1'b0;
                        s0_axi_wready  <= 1'b0;
                        s0_axi_bvalid  <= 1'b1;
                        s0_axi_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                    end else if (aw_hs) begin
                        w_state        <= W_HAVE_ADDR;
                        addr_q         <= s0_axi_awaddr;
                        s0_axi_awready <= 1'b0;
                    end else if (w_hs) begin
                        w_state       <= W_HAVE_DATA;
                        data_q        <= s0_axi_wdata;
                        strb_q        <= s0_axi_wstrb;
                        s0_axi_wready <= 1'b0;
                    end
                end
                W_HAVE_ADDR, W_HAVE_DATA: begin
                    if (wr_fire) begin
                        w_state        <= W_RESP;
                        s0_axi_awready <= 1'b0;
                        s0_axi_wready  <= 1'b0;
                        s0_axi_bvalid  <= 1'b1;
                        s0_axi_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        w_state        <= W_IDLE;
                        s0_axi_bvalid  <= 1'b0;
                        s0_axi_awready <= 1'b1;
                        s0_axi_wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Reads sample mem before this edge's write lands, so a same-edge collision returns old data.
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            r_state        <= R_IDLE;
            s0_axi_arready <= 1'b0;
            s0_axi_rvalid  <= 1'b0;
            s0_axi_rdata   <= '0;
            s0_axi_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s0_axi_arready <= 1'b1;
                    if (ar_hs) begin
                        r_state        <= R_VALID;
                        s0_axi_arready <= 1'b0;
                        s0_axi_rvalid  <= 1'b1;
                        if (|s0_axi_araddr[1:0]) begin
                            s0_axi_rdata <= '0;
                            s0_axi_rresp <= RESP_SLVERR;
                        end else begin
                            s0_axi_rdata <= mem[s0_axi_araddr[ADDR_WIDTH-1:2]];
                            s0_axi_rresp <= RESP_OKAY;
                        end
                    end
                end
                R_VALID: begin
                    if (r_hs) begin
                        r_state        <= R_IDLE;
                        s0_axi_rvalid  <= 1'b0;
                        s0_axi_arready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            mem <= '0;
        end else if (wr_fire && !wr_err) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_strb[b])
                    mem[wr_addr[ADDR_WIDTH-1:2]][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Bench for axi_lite_mem_slave: directed scenarios plus randomized traffic
// checked against a word-array memory model.
module tb_axi_lite_mem_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int total = 0;
    int bad = 0;
    logic [31:0] ref_mem [64];

    always #5 clk = ~clk;

    axi_lite_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .s0_axi_aclk(clk), .s0_axi_aresetn(rst_n),
        .s0_axi_awaddr(awaddr), .s0_axi_awvalid(awvalid), .s0_axi_awready(awready),
        .s0_axi_wdata(wdata), .s0_axi_wstrb(wstrb), .s0_axi_wvalid(wvalid), .s0_axi_wready(wready),
        .s0_axi_bresp(bresp), .s0_axi_bvalid(bvalid), .s0_axi_bready(bready),
        .s0_axi_araddr(araddr), .s0_axi_arvalid(arvalid), .s0_axi_arready(arready),
        .s0_axi_rdata(rdata), .s0_axi_rresp(rresp), .s0_axi_rvalid(rvalid), .s0_axi_rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void mdl_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a[1:0] == 2'b00)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a[7:2]][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [7:0] a);
        return (a[1:0] != 2'b00) ? 32'h0 : ref_mem[a[7:2]];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write with AW offered after daw cycles and W after dw cycles; B held off for bhold cycles.
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int daw, input int dw, input int bhold);
        bit aw_done, w_done, aw_fire, w_fire, bv_early;
        int n;
        logic [1:0] resp_q;
        aw_done = 0; w_done = 0; bv_early = 0; n = 0;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && n < 200) begin
            awvalid = !aw_done && (n >= daw);
            wvalid  = !w_done && (n >= dw);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            if (bvalid) bv_early = 1;
            step();
            n++;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            if (w_fire && !aw_done) chk("wready_drop", wready, 0);
            if (aw_fire && !w_done) chk("awready_drop", awready, 0);
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) begin
            chk("wr_timeout", 0, 1);
            return;
        end
        chk("bvalid_early", bv_early, 0);
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, (a[1:0] != 2'b00) ? 2 : 0);
        mdl_wr(a, d, s);
        resp_q = bresp;
        awaddr = a + 8'd4;
        for (int i = 0; i < bhold; i++) begin
            awvalid = 1;
            chk("bp_bvalid", bvalid, 1);
            chk("bp_bresp", bresp, resp_q);
            chk("bp_ready", {awready, wready}, 0);
            step();
        end
        awvalid = 0;
        bready = 1;
        step();
        bready = 0;
        chk("b_done", bvalid, 0);
        chk("b_done_rdy", {awready, wready}, 2'b11);
    endtask

    task automatic rd(input logic [7:0] a, input int rhold, output logic [31:0] d);
        int n;
        logic [31:0] exp, held;
        n = 0;
        exp = mdl_rd(a);
        araddr = a; arvalid = 1;
        while (!arready && n < 50) begin
            step();
            n++;
        end
        chk("rvalid_pre", rvalid, 0);
        step();
        arvalid = 0;
        chk("rvalid", rvalid, 1);
        chk("rresp", rresp, (a[1:0] != 2'b00) ? 2 : 0);
        chk("rdata", rdata, exp);
        d = rdata;
        held = rdata;
        for (int i = 0; i < rhold; i++) begin
            step();
            chk("rp_hold", {31'b0, rvalid}, 1);
            chk("rp_rdata", rdata, held);
            chk("rp_arready", arready, 0);
        end
        rready = 1;
        step();
        rready = 0;
        chk("r_done", rvalid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  a;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        #2 rst_n = 0;
        #1;
        chk("rst_ready", {awready, wready, arready}, 0);
        chk("rst_valid", {bvalid, rvalid}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_hold_ready", {awready, wready, arready}, 0);
        step();
        chk("first_edge_ready", {awready, wready, arready}, 3'b111);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_ready", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
        end

        rd(8'h00, 0, d);
        wr(8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        rd(8'h10, 0, d);
        chk("rd_10", d, 32'hDEADBEEF);

        wr(8'h20, 32'h12345678, 4'hF, 3, 0, 0);
        wr(8'h24, 32'h12345678, 4'hF, 0, 3, 0);
        rd(8'h20, 0, d);
        chk("rd_20", d, 32'h12345678);
        rd(8'h24, 1, d);
        chk("rd_24", d, 32'h12345678);

        wr(8'h30, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        wr(8'h30, 32'hA5A5A5A5, 4'b0101, 1, 0, 0);
        rd(8'h30, 0, d);
        chk("rd_strb", d, 32'hFFA5FFA5);
        wr(8'h30, 32'h00000000, 4'h0, 0, 0, 0);
        rd(8'h30, 0, d);
        chk("rd_nostrb", d, 32'hFFA5FFA5);

        wr(8'h40, 32'hC0FFEE00, 4'hF, 0, 0, 5);
        rd(8'h40, 3, d);

        wr(8'h50, 32'h11111111, 4'hF, 0, 0, 0);
        awaddr = 8'h50; wdata = 32'h22222222; wstrb = 4'hF; araddr = 8'h50;
        awvalid = 1; wvalid = 1; arvalid = 1;
        chk("coll_rdy", {awready, wready, arready}, 3'b111);
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("coll_valid", {bvalid, rvalid}, 2'b11);
        chk("coll_rdata", rdata, 32'h11111111);
        mdl_wr(8'h50, 32'h22222222, 4'hF);
        bready = 1; rready = 1;
        step();
        bready = 0; rready = 0;
        rd(8'h50, 0, d);
        chk("coll_after", d, 32'h22222222);

        wr(8'h52, 32'h33333333, 4'hF, 0, 0, 0);
        rd(8'h50, 0, d);
        chk("unal_wr_nochg", d, 32'h22222222);
        rd(8'h53, 0, d);
        chk("unal_rd_zero", d, 32'h0);

        for (int t = 0; t < 60; t++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1)
                wr(a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                rd(a, $urandom_range(0, 3), d);
        end

        rd(8'h40, 0, d);
        awaddr = 8'h60; awvalid = 1;
        step();
        awvalid = 0;
        chk("mid_have_addr", {awready, wready}, 2'b01);
        rst_n = 0;
        #1;
        chk("mid_rst_rdy", {awready, wready, arready, bvalid, rvalid}, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_resp", {bresp, rresp}, 0);
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        @(posedge clk);
        #1 rst_n = 1;
        step();
        chk("mid_rdy", {awready, wready, arready}, 3'b111);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_b", bvalid, 0);
        end
        rd(8'h60, 0, d);
        chk("mid_mem60", d, 32'h0);
        rd(8'h10, 0, d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_mem_slave.md
# axi_lite_mem_slave

AXI4-Lite responder backed by a word-addressed register-file memory, terminating the master-side (`m1_axi_*`) port of the bus bridge. The block accepts write address and write data independently, in either order, and performs byte-strobed writes. It returns single-cycle-latency reads. It is the memory target for bridge bring-up and for system tests.

## Interface
- `DATA_WIDTH`, 32: data bus width; must be 32.
- `ADDR_WIDTH`, 8: byte address width; memory depth is DEPTH = 2^(ADDR_WIDTH-2) words (64 at default).

Ports:
- `s0_axi_aclk` in 1: single clock; all logic is rising-edge.
- `s0_axi_aresetn` in 1: reset, asynchronous, active-low.
- `s0_axi_awaddr` in ADDR_WIDTH: write byte address.
- `s0_axi_awvalid` in 1 / `s0_axi_awready` out 1: write address handshake.
- `s0_axi_wdata` in DATA_WIDTH: write data.
- `s0_axi_wstrb` in DATA_WIDTH/8: byte enables; bit i enables byte lane `wdata[8i+7:8i]`.
- `s0_axi_wvalid` in 1 / `s0_axi_wready` out 1: write data handshake.
- `s0_axi_bresp` out 2: write response; 2'b00 = OKAY, 2'b10 = SLVERR.
- `s0_axi_bvalid` out 1 / `s0_axi_bready` in 1: write response handshake.
- `s0_axi_araddr` in ADDR_WIDTH: read byte address.
- `s0_axi_arvalid` in 1 / `s0_axi_arready` out 1: read address handshake.
- `s0_axi_rdata` out DATA_WIDTH: read data.
- `s0_axi_rresp` out 2: read response; encoding as `bresp`.
- `s0_axi_rvalid` out 1 / `s0_axi_rready` in 1: read data handshake.

## Operation
- A handshake occurs on any rising edge where valid and ready are both 1.
- Word index is `addr[ADDR_WIDTH-1:2]`.
- An address with `addr[1:0] != 0` is unaligned. An unaligned write returns SLVERR and leaves memory unchanged. An unaligned read returns SLVERR with rdata = 0.
- Write FSM states and transitions:
  - W_IDLE: awready = 1, wready = 1.
    - AW and W handshake on the same edge: execute the write, go to W_RESP.
    - AW handshake only: latch address, go to W_HAVE_ADDR.
    - W handshake only: latch wdata and wstrb, go to W_HAVE_DATA.
  - W_HAVE_ADDR: awready = 0, wready = 1. On W handshake: execute the write, go to W_RESP.
  - W_HAVE_DATA: awready = 1, wready = 0. On AW handshake: execute the write, go to W_RESP.
  - W_RESP: awready = 0, wready = 0, bvalid = 1, bresp held stable. On bready: go to W_IDLE.
- Write execution updates only the byte lanes whose strobe bit is 1. wstrb = 0 is a legal no-op write and returns OKAY.
- Read FSM states and transitions:
  - R_IDLE: arready = 1. On AR handshake: register rdata = mem[index] (or 0 if unaligned) and rresp, go to R_VALID.
  - R_VALID: arready = 0, rvalid = 1, rdata and rresp held stable. On rready: go to R_IDLE.
- The read and write FSMs are fully independent and may handshake on the same edge.
- Read and write to the same word on the same edge: the read returns the pre-write contents.
- A write completing on edge N is visible to any AR handshake on edge N+1 or later.
- valid is never withdrawn by this block before its handshake completes.

## Timing
- All outputs are registered. ready signals are registered versions of the FSM decode above.
- Reset values, all asserted asynchronously on the falling edge of aresetn:
  - awready, wready, arready, bvalid and rvalid are 0.
  - bresp, rresp and rdata are 0.
  - Both FSMs are in their IDLE state and all memory words are 0.
- The first rising edge with aresetn = 1 sets awready, wready and arready to 1.
- Write response latency: the completing handshake on edge N gives bvalid = 1 after edge N.
- Read latency: the AR handshake on edge N gives rvalid = 1 and valid rdata after edge N.
- Maximum throughput is one write per 2 cycles and one read per 2 cycles, with bready/rready held at 1.
- Backpressure: bvalid and rvalid hold for an unbounded number of cycles with bready/rready = 0. No new AW, W or AR is accepted meanwhile.
- Reset mid-transaction discards any latched address or data with no memory write. A pending bvalid or rvalid drops immediately.

## Test plan
- Reset and basic traffic:
  - Reset, then idle 3 cycles: awready, wready and arready = 1 from the first post-reset edge.
  - Read 0x00: rdata = 0x00000000, rresp = 00.
  - Write 0x10 = 0xDEADBEEF with wstrb = 4'hF, AW and W on the same cycle: bvalid on the next cycle, bresp = 00.
  - Read 0x10: rdata = 0xDEADBEEF, rvalid exactly 1 cycle after the AR handshake.
- AW/W ordering:
  - W sent 3 cycles before AW (addr 0x20, data 0x12345678): wready falls after the W handshake, bvalid follows the AW handshake by 1 cycle.
  - Repeat with AW first (addr 0x24): readback 0x12345678 at both addresses.
- Byte strobes: write 0x30 = 0xFFFFFFFF, then 0x30 = 0xA5A5A5A5 with wstrb = 4'b0101. Readback = 0xFFA5FFA5.
- Backpressure: write 0x40 with bready = 0 for 5 cycles. bvalid and bresp stay stable, awready = wready = 0 throughout, and a second AW is not accepted until after the B handshake.
- Same-edge collision and errors:
  - mem[0x50] = 0x11111111. Write 0x50 = 0x22222222 and AR 0x50 on the same edge: read returns 0x11111111; the next read returns 0x22222222.
  - Write 0x52: bresp = 10, memory unchanged.
  - Read 0x53: rresp = 10, rdata = 0.
- Reset mid-operation: hold AW(0x60) only, then pulse aresetn low for 1 cycle. Outputs return to reset values immediately, no bvalid appears afterwards, and mem[0x60] = 0.
